idex_forward_reg: RTL

IDEX_FORWARD_REG -- requirements
Module: idex_forward_reg

---
 rtl/idex_forward_reg.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/idex_forward_reg.sv
`default_nettype none
// ============================================================================
//  Module   : idex_forward_reg
//  Brief    : ID/EX pipeline register with operand forwarding muxes, flush
//             bubbles, stall hold with forward capture and a bubble counter.
//  Revision : 1.0  initial release
// ============================================================================
module idex_forward_reg (
    input  logic        clk,
    input  logic        rst,

    input  logic        valid_d,
    input  logic [4:0]  rs_addr1D,
    input  logic [4:0]  rs_addr2D,
    input  logic [4:0]  rd_addrD,
    input  logic        rd_wrenD,
    input  logic        wb_D,
    input  logic [3:0]  alu_opD,
    input  logic [31:0] rs_data1D,
    input  logic [31:0] rs_data2D,
    input  logic [31:0] imm_D,
    input  logic [31:0] pc_D,

    input  logic        flush_e,
    input  logic        stall_e,
    input  logic [1:0]  ex_1sel,
    input  logic [1:0]  ex_2sel,
    input  logic [31:0] alu_resultM,
    input  logic [31:0] wb_dataW,

    output logic        valid_e,
    output logic [4:0]  rs_addr1E,
    output logic [4:0]  rs_addr2E,
    output logic [4:0]  rd_addrE,
    output logic        rd_wrenE,
    output logic        wb_E,
    output logic [3:0]  alu_opE,
    output logic [31:0] pc_E,
    output logic [31:0] imm_E,
    output logic [31:0] op_aE,
    output logic [31:0] op_bE,
    output logic [15:0] bubble_cnt
);

    localparam logic [1:0]  SEL_M   = 2'b01;
    localparam logic [1:0]  SEL_W   = 2'b10;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    logic        valid_q,     valid_d_nx;
    logic [4:0]  rs_addr1_q,  rs_addr1_d;
    logic [4:0]  rs_addr2_q,  rs_addr2_d;
    logic [4:0]  rd_addr_q,   rd_addr_d;
    logic        rd_wren_q,   rd_wren_d;
    logic        wb_q,        wb_d;
    logic [3:0]  alu_op_q,    alu_op_d;
    logic [31:0] pc_q,        pc_d;
    logic [31:0] imm_q,       imm_d;
    logic [31:0] rs_data1_q,  rs_data1_d;
    logic [31:0] rs_data2_q,  rs_data2_d;
    logic [15:0] bubble_cnt_q, bubble_cnt_d;

    logic [31:0] w_op_a;
    logic [31:0] w_op_b;

    // Same-cycle forwarding; select 11 falls back to the register value
    always_comb begin
        case (ex_1sel)
            SEL_M:   w_op_a = alu_resultM;
            SEL_W:   w_op_a = wb_dataW;
            default: w_op_a = rs_data1_q;
        endcase
        case (ex_2sel)
            SEL_M:   w_op_b = alu_resultM;
            SEL_W:   w_op_b = wb_dataW;
            default: w_op_b = rs_data2_q;
        endcase
    end

    always_comb begin
        valid_d_nx   = valid_q;
        rs_addr1_d   = rs_addr1_q;
        rs_addr2_d   = rs_addr2_q;
        rd_addr_d    = rd_addr_q;
        rd_wren_d    = rd_wren_q;
        wb_d         = wb_q;
        alu_op_d     = alu_op_q;
        pc_d         = pc_q;
        imm_d        = imm_q;
        rs_data1_d   = rs_data1_q;
        rs_data2_d   = rs_data2_q;
        bubble_cnt_d = bubble_cnt_q;

        if (flush_e) begin
            valid_d_nx = 1'b0;
            rs_addr1_d = 5'd0;
            rs_addr2_d = 5'd0;
            rd_addr_d  = 5'd0;
            rd_wren_d  = 1'b0;
            wb_d       = 1'b0;
            alu_op_d   = 4'd0;
            pc_d       = 32'd0;
            imm_d      = 32'd0;
            rs_data1_d = 32'd0;
            rs_data2_d = 32'd0;
        end else if (stall_e) begin
            // Keep whatever is being forwarded now, its producer may move on
            rs_data1_d = w_op_a;
            rs_data2_d = w_op_b;
        end else begin
            valid_d_nx = valid_d;
            rs_addr1_d = rs_addr1D;
            rs_addr2_d = rs_addr2D;
            rd_addr_d  = rd_addrD;
            rd_wren_d  = rd_wrenD;
            wb_d       = wb_D;
            alu_op_d   = alu_opD;
            pc_d       = pc_D;
            imm_d      = imm_D;
            rs_data1_d = rs_data1D;
            rs_data2_d = rs_data2D;
        end

        if ((flush_e || !stall_e) && !valid_d_nx && (bubble_cnt_q != CNT_MAX)) begin
            bubble_cnt_d = bubble_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q      <= 1'b0;
            rs_addr1_q   <= 5'd0;
            rs_addr2_q   <= 5'd0;
            rd_addr_q    <= 5'd0;
            rd_wren_q    <= 1'b0;
            wb_q         <= 1'b0;
            alu_op_q     <= 4'd0;
            pc_q         <= 32'd0;
            imm_q        <= 32'd0;
            rs_data1_q   <= 32'd0;
            rs_data2_q   <= 32'd0;
            bubble_cnt_q <= 16'd0;
        end else begin
            valid_q      <= valid_d_nx;
            rs_addr1_q   <= rs_addr1_d;
            rs_addr2_q   <= rs_addr2_d;
            rd_addr_q    <= rd_addr_d;
            rd_wren_q    <= rd_wren_d;
            wb_q         <= wb_d;
            alu_op_q     <= alu_op_d;
            pc_q         <= pc_d;
            imm_q        <= imm_d;
            rs_data1_q   <= rs_data1_d;
            rs_data2_q   <= rs_data2_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign valid_e    = valid_q;
    assign rs_addr1E  = rs_addr1_q;
    assign rs_addr2E  = rs_addr2_q;
    assign rd_addrE   = rd_addr_q;
    assign rd_wrenE   = rd_wren_q;
    assign wb_E       = wb_q;
    assign alu_opE    = alu_op_q;
    assign pc_E       = pc_q;
    assign imm_E      = imm_q;
    assign op_aE      = w_op_a;
    assign op_bE      = w_op_b;
    assign bubble_cnt = bubble_cnt_q;

endmodule
`default_nettype wire
